ps2_key_ctrl: RTL and testbench

Scan-code sequencer and event buffer placed directly behind the PS/2 byte receiver. It polls the receiver through its spa/cap handshake and decodes the set-2 prefixes (E0, F0, the E1 pause sequence). It turns the byte stream into 10-bit key events and queues them in a small FIFO for the downstream consumer, such as the VGA text front-end. It also flags keyboard self-test results, protocol errors and buffer overflow.

---
 rtl/ps2_key_ctrl_if.sv | 24 ++
 rtl/ps2_key_ctrl.sv | 169 ++++++++++++++++
 tb/tb_ps2_key_ctrl.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_key_ctrl_if.sv
// Bundles the byte-receiver poll/capture lines, the key-event stream and the status flags.
// The master modport is the controller side. The slave modport is the receiver/consumer side.
interface ps2_key_ctrl_if;
  logic       i_cap;
  logic [7:0] i_dap;
  logic       o_spa;
  logic       o_valid;
  logic [9:0] o_key;
  logic       i_ready;
  logic       o_ovf;
  logic       i_clr_ovf;
  logic       o_bat;
  logic       o_kerr;

  modport master (
    input  i_cap, i_dap, i_ready, i_clr_ovf,
    output o_spa, o_valid, o_key, o_ovf, o_bat, o_kerr
  );

  modport slave (
    output i_cap, i_dap, i_ready, i_clr_ovf,
    input  o_spa, o_valid, o_key, o_ovf, o_bat, o_kerr
  );
endinterface

// File: rtl/ps2_key_ctrl.sv
// Set-2 scan-code decoder feeding a show-ahead event FIFO; events are visible one cycle after capture.
// Backpressure: o_spa drops at DEPTH-1 entries, and a push into a full FIFO without a pop is dropped and flagged.
module ps2_key_ctrl #(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 1000000
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  ps2_key_ctrl_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [CW-1:0] SPA_MAX  = CW'(DEPTH - 2);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  typedef enum logic [2:0] {IDLE, EXT, BRK, EXT_BRK, PAUSE} state_t;

  state_t          state_q, state_d;
  logic [2:0]      pcnt_q, pcnt_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic            bat_q, bat_d, kerr_q, kerr_d;
  logic            ovf_q, ovf_d, run_q, run_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [9:0]      mem_q [DEPTH];

  logic            push, pop, full, wr_en, is_pfx;
  logic [9:0]      push_key;
  logic [7:0]      dap;

  assign dap    = bus.i_dap;
  assign is_pfx = (dap == 8'hE0) || (dap == 8'hF0) || (dap == 8'hE1);

  always_comb begin
    state_d  = state_q;
    pcnt_d   = pcnt_q;
    tmo_d    = tmo_q;
    bat_d    = 1'b0;
    kerr_d   = 1'b0;
    push     = 1'b0;
    push_key = '0;
    if (bus.i_cap) begin
      tmo_d = '0;
      case (dap)
        8'hAA: begin
          bat_d   = 1'b1;
          state_d = IDLE;
          pcnt_d  = '0;
        end
        8'hFC, 8'h00, 8'hFF: begin
          kerr_d  = 1'b1;
          state_d = IDLE;
          pcnt_d  = '0;
        end
        8'hFA, 8'hEE, 8'hFE: ;
        default: begin
          case (state_q)
            IDLE: begin
              if (dap == 8'hE0) state_d = EXT;
              else if (dap == 8'hF0) state_d = BRK;
              else if (dap == 8'hE1) begin
                state_d = PAUSE;
                pcnt_d  = '0;
              end else begin
                push     = 1'b1;
                push_key = {2'b00, dap};
              end
            end
            EXT: begin
              if (dap == 8'hF0) state_d = EXT_BRK;
              else if (dap == 8'hE1) begin
                state_d = IDLE;
                kerr_d  = 1'b1;
              end else if (dap != 8'hE0) begin
                push     = 1'b1;
                push_key = {2'b01, dap};
                state_d  = IDLE;
              end
            end
            BRK, EXT_BRK: begin
              state_d = IDLE;
              if (is_pfx) kerr_d = 1'b1;
              else begin
                push     = 1'b1;
                push_key = {1'b1, state_q == EXT_BRK, dap};
              end
            end
            PAUSE: begin
              // Seven bytes follow E1; they collapse into a single pause event.
              if (pcnt_q == 3'd6) begin
                push     = 1'b1;
                push_key = 10'h1E1;
                state_d  = IDLE;
                pcnt_d   = '0;
              end else begin
                pcnt_d = pcnt_q + 3'd1;
              end
            end
            default: state_d = IDLE;
          endcase
        end
      endcase
    end else if (state_q != IDLE) begin
      if (tmo_q == TMO_LAST) begin
        state_d = IDLE;
        kerr_d  = 1'b1;
        tmo_d   = '0;
        pcnt_d  = '0;
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
    end
  end

  always_comb begin
    full     = (cnt_q == CNT_FULL);
    pop      = (cnt_q != '0) && bus.i_ready;
    // A pop frees the head slot, so a push into a full FIFO still lands.
    wr_en    = push && (!full || pop);
    wr_ptr_d = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    case ({wr_en, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
    ovf_d = (push && full && !pop) || (ovf_q && !bus.i_clr_ovf);
    run_d = 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      pcnt_q   <= '0;
      tmo_q    <= '0;
      bat_q    <= 1'b0;
      kerr_q   <= 1'b0;
      ovf_q    <= 1'b0;
      run_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      pcnt_q   <= pcnt_d;
      tmo_q    <= tmo_d;
      bat_q    <= bat_d;
      kerr_q   <= kerr_d;
      ovf_q    <= ovf_d;
      run_q    <= run_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst_n && wr_en) mem_q[wr_ptr_q] <= push_key;
  end

  assign bus.o_valid = (cnt_q != '0);
  assign bus.o_key   = bus.o_valid ? mem_q[rd_ptr_q] : '0;
  assign bus.o_spa   = run_q && (cnt_q <= SPA_MAX);
  assign bus.o_ovf   = ovf_q;
  assign bus.o_bat   = bat_q;
  assign bus.o_kerr  = kerr_q;
endmodule

// File: tb/tb_ps2_key_ctrl.sv
// Randomized and directed bench for ps2_key_ctrl against a byte-sequence reference model.
module tb_ps2_key_ctrl;
  localparam int DEPTH = 8;
  localparam int TMO   = 50;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ps2_key_ctrl_if bus();

  ps2_key_ctrl #(.DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // Reference state: prefix bytes seen since the last completed sequence, and the event queue.
  logic [7:0] pend[$];
  logic [9:0] mq[$];
  int  idle_cnt = 0;
  bit  m_ovf = 1'b0, m_bat = 1'b0, m_kerr = 1'b0, m_run = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit has_byte(input logic [7:0] b);
    foreach (pend[i]) if (pend[i] == b) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_byte(input logic [7:0] b, output bit ev, output logic [9:0] key,
                            output bit kerr, output bit bat);
    ev = 1'b0; key = '0; kerr = 1'b0; bat = 1'b0;
    if (b == 8'hFA || b == 8'hEE || b == 8'hFE) return;
    if (b == 8'hAA) begin bat = 1'b1; pend.delete(); return; end
    if (b == 8'hFC || b == 8'h00 || b == 8'hFF) begin kerr = 1'b1; pend.delete(); return; end
    if (pend.size() > 0 && pend[0] == 8'hE1) begin
      pend.push_back(b);
      if (pend.size() == 8) begin ev = 1'b1; key = 10'h1E1; pend.delete(); end
      return;
    end
    if (b != 8'hE0 && b != 8'hF0 && b != 8'hE1) begin
      ev = 1'b1;
      key = {has_byte(8'hF0), has_byte(8'hE0), b};
      pend.delete();
      return;
    end
    if (pend.size() == 0) begin pend.push_back(b); return; end
    if (has_byte(8'hF0)) begin kerr = 1'b1; pend.delete(); return; end
    if (b == 8'hE0) return;
    if (b == 8'hF0) begin pend.push_back(b); return; end
    kerr = 1'b1;
    pend.delete();
  endtask

  task automatic model_edge(input logic rst, input logic cap, input logic [7:0] d,
                            input logic rdy, input logic clr);
    bit ev, kerr, bat, pop;
    logic [9:0] key;
    if (!rst) begin
      pend.delete(); mq.delete(); idle_cnt = 0;
      m_ovf = 1'b0; m_bat = 1'b0; m_kerr = 1'b0; m_run = 1'b0;
      return;
    end
    pop = (mq.size() > 0) && rdy;
    ev = 1'b0; kerr = 1'b0; bat = 1'b0; key = '0;
    if (cap) begin
      model_byte(d, ev, key, kerr, bat);
      idle_cnt = 0;
    end else if (pend.size() > 0) begin
      idle_cnt++;
      if (idle_cnt == TMO) begin kerr = 1'b1; pend.delete(); idle_cnt = 0; end
    end
    if (pop) void'(mq.pop_front());
    if (ev && mq.size() >= DEPTH) m_ovf = 1'b1;
    else begin
      if (ev) mq.push_back(key);
      if (clr) m_ovf = 1'b0;
    end
    m_bat = bat; m_kerr = kerr; m_run = 1'b1;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("spa",   32'(bus.o_spa),   32'(m_run && mq.size() <= DEPTH - 2));
      check("valid", 32'(bus.o_valid), 32'(mq.size() > 0));
      if (mq.size() > 0) check("key", 32'(bus.o_key), 32'(mq[0]));
      else               check("key_idle", 32'(bus.o_key), 32'd0);
      check("ovf",  32'(bus.o_ovf),  32'(m_ovf));
      check("bat",  32'(bus.o_bat),  32'(m_bat));
      check("kerr", 32'(bus.o_kerr), 32'(m_kerr));
    end
  end

  task automatic step(input logic c, input logic [7:0] d, input logic r, input logic cl);
    bus.i_cap = c; bus.i_dap = d; bus.i_ready = r; bus.i_clr_ovf = cl;
    @(posedge clk);
    model_edge(rst_n, c, d, r, cl);
    @(negedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b); step(1'b1, b, 1'b0, 1'b0); endtask
  task automatic pop1(); step(1'b0, 8'h00, 1'b1, 1'b0); endtask
  task automatic idle(input int n); for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 1'b0); endtask

  task automatic expect_pop(input string name, input logic [9:0] k);
    check(name, 32'(bus.o_key), 32'(k));
    pop1();
  endtask

  logic [7:0] pause_seq [8];

  initial begin
    int kc;
    logic [7:0] b;
    bus.i_cap = 1'b0; bus.i_dap = '0; bus.i_ready = 1'b0; bus.i_clr_ovf = 1'b0;
    chk_en = 1'b1;
    rst_n = 1'b0;
    idle(3);
    check("rst_spa", 32'(bus.o_spa), 32'd0);
    check("rst_valid", 32'(bus.o_valid), 32'd0);
    rst_n = 1'b1;
    idle(1);
    check("run_spa", 32'(bus.o_spa), 32'd1);

    send(8'h1C);
    check("first_valid", 32'(bus.o_valid), 32'd1);
    check("first_key", 32'(bus.o_key), 32'h01C);
    pop1();
    check("first_popped", 32'(bus.o_valid), 32'd0);

    send(8'hF0); send(8'h1C); send(8'hE0); send(8'h75);
    send(8'hE0); send(8'hF0); send(8'h75);
    expect_pop("brk", 10'h21C);
    expect_pop("ext", 10'h175);
    expect_pop("ext_brk", 10'h375);
    check("three_only", 32'(bus.o_valid), 32'd0);

    pause_seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    foreach (pause_seq[i]) send(pause_seq[i]);
    expect_pop("pause", 10'h1E1);
    check("pause_single", 32'(bus.o_valid), 32'd0);
    send(8'hE1); send(8'h14); send(8'hFF);
    check("pause_abort_kerr", 32'(bus.o_kerr), 32'd1);
    check("pause_abort_noev", 32'(bus.o_valid), 32'd0);

    for (int i = 0; i < 7; i++) begin
      send(8'(8'h10 + i));
      if (i == 5) check("spa_at6", 32'(bus.o_spa), 32'd1);
    end
    check("spa_at7", 32'(bus.o_spa), 32'd0);
    send(8'h17);
    send(8'h18);
    check("ovf_set", 32'(bus.o_ovf), 32'd1);
    for (int i = 0; i < 8; i++) expect_pop("drain", 10'(10'h10 + i));
    check("drained", 32'(bus.o_valid), 32'd0);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    check("ovf_clr", 32'(bus.o_ovf), 32'd0);

    for (int i = 0; i < 8; i++) send(8'(8'h20 + i));
    step(1'b1, 8'h28, 1'b1, 1'b0);
    check("full_pushpop_ovf", 32'(bus.o_ovf), 32'd0);
    check("full_pushpop_head", 32'(bus.o_key), 32'h021);
    for (int i = 0; i < 8; i++) expect_pop("drain2", 10'(10'h21 + i));

    send(8'hE0);
    kc = 0;
    for (int i = 0; i < TMO + 3; i++) begin
      idle(1);
      if (bus.o_kerr) kc++;
    end
    check("tmo_kerr_cnt", 32'(kc), 32'd1);
    send(8'h1C);
    expect_pop("after_tmo", 10'h01C);

    send(8'hE0);
    idle(TMO - 1);
    send(8'h1C);
    check("tmo_race_kerr", 32'(bus.o_kerr), 32'd0);
    expect_pop("tmo_race_key", 10'h11C);

    send(8'hAA);
    check("bat_pulse", 32'(bus.o_bat), 32'd1);
    check("bat_noev", 32'(bus.o_valid), 32'd0);
    idle(1);
    check("bat_once", 32'(bus.o_bat), 32'd0);

    send(8'h33); send(8'hE0); send(8'hF0);
    rst_n = 1'b0;
    idle(2);
    check("midrst_valid", 32'(bus.o_valid), 32'd0);
    check("midrst_spa", 32'(bus.o_spa), 32'd0);
    rst_n = 1'b1;
    idle(1);
    check("rel_spa", 32'(bus.o_spa), 32'd1);
    send(8'h1C);
    expect_pop("after_rst", 10'h01C);

    for (int ph = 0; ph < 12; ph++) begin
      int cap_div;
      cap_div = (ph % 3 == 2) ? 60 : ((ph % 3 == 1) ? 12 : 2);
      for (int i = 0; i < 250; i++) begin
        int r;
        r = int'($urandom_range(0, 19));
        case (r)
          0, 1, 2: b = 8'hE0;
          3, 4:    b = 8'hF0;
          5:       b = 8'hE1;
          6:       b = 8'hAA;
          7:       b = 8'hFF;
          8:       b = 8'hFA;
          9:       b = 8'h00;
          default: b = 8'($urandom_range(1, 127));
        endcase
        step(($urandom_range(0, cap_div - 1) == 0), b,
             ($urandom_range(0, 2) == 0), ($urandom_range(0, 49) == 0));
      end
    end

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
